// File: rtl/dmem_req_ctrl_pkg.sv
// Shared pipeline definitions for the data-memory request controller:
// FSM encoding, timeout default and address/width helpers.
package dmem_req_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;
   localparam logic [31:0] WORD_ALIGN_MASK        = 32'hFFFF_FFFC;

   // Memory is word-addressed on this port; byte offset is dropped.
   function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
      return byte_addr & WORD_ALIGN_MASK;
   endfunction

   function automatic int unsigned timer_width(input int unsigned limit);
      return (limit < 32'd1) ? 32'd1 : $clog2(limit + 32'd1);
   endfunction

endpackage

// File: rtl/dmem_req_ctrl_wait_timer.sv
// Wait-cycle counter: counts enabled cycles and flags the cycle whose
// increment would reach the limit.
module dmem_req_ctrl_wait_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expired
);

   logic [WIDTH-1:0] count_r;
   logic [WIDTH:0]   next_s;

   // Expiry is seen in the same cycle so the FSM can abort at this edge.
   always_comb begin
      next_s  = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
      expired = 1'b0;
      if (enable) begin
         expired = (next_s >= {1'b0, limit});
      end else begin
         expired = 1'b0;
      end
   end

   // Counter register with clear taking priority over increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clear) begin
         count_r <= {WIDTH{1'b0}};
      end else if (enable) begin
         count_r <= next_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data-memory request controller: latches a load/store, stalls the
// pipeline while memory responds, aborts with a sticky flag on timeout.
module dmem_req_ctrl
   import dmem_req_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic [31:0] MemA,
   output logic [31:0] MemWD,
   output logic        MemWE,
   input  logic        MemReady,
   input  logic [31:0] MemRD,
   output logic        Timeout
);

   localparam int unsigned     CW    = timer_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

   state_t      state_r;
   logic        op_write_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [31:0] rdata_r;
   logic        timeout_r;
   logic        memwe_r;

   logic        req_s;
   logic        timer_clear_s;
   logic        timer_enable_s;
   logic        expired_s;
   logic        stall_s;

   assign req_s          = MemRead | MemWrite;
   assign timer_clear_s  = (state_r == IDLE) && req_s;
   assign timer_enable_s = (state_r == WAIT) && !MemReady;

   dmem_req_ctrl_wait_timer #(
      .WIDTH (CW)
   ) wait_timer (
      .clk     (CLK),
      .reset   (Reset),
      .clear   (timer_clear_s),
      .enable  (timer_enable_s),
      .limit   (LIMIT),
      .expired (expired_s)
   );

   // Stall must rise in the request cycle itself, so it is decoded from state.
   always_comb begin
      stall_s = 1'b0;
      if (Reset) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    stall_s = req_s;
            WAIT:    stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
         endcase
      end
   end

   // Request FSM with all memory-side outputs held in registers.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_r    <= IDLE;
         op_write_r <= 1'b0;
         addr_r     <= 32'h0000_0000;
         wdata_r    <= 32'h0000_0000;
         rdata_r    <= 32'h0000_0000;
         timeout_r  <= 1'b0;
         memwe_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_s) begin
                  addr_r     <= word_align(Addr);
                  wdata_r    <= WriteData;
                  op_write_r <= MemWrite;
                  memwe_r    <= MemWrite;
                  state_r    <= WAIT;
               end
            end
            WAIT: begin
               // MemReady outranks a simultaneous expiry.
               if (MemReady) begin
                  if (!op_write_r) begin
                     rdata_r <= MemRD;
                  end
                  memwe_r <= 1'b0;
                  state_r <= DONE;
               end else if (expired_s) begin
                  if (!op_write_r) begin
                     rdata_r <= 32'h0000_0000;
                  end
                  timeout_r <= 1'b1;
                  memwe_r   <= 1'b0;
                  state_r   <= DONE;
               end
            end
            DONE: begin
               memwe_r <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               memwe_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign Stall    = stall_s;
   assign ReadData = rdata_r;
   assign MemA     = addr_r;
   assign MemWD    = wdata_r;
   assign MemWE    = memwe_r;
   assign Timeout  = timeout_r;

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: max WAIT cycles without MemReady before abort.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 MemRead  input  1  MEM-stage load request.
REQ-005 MemWrite  input  1  MEM-stage store request.
REQ-006 Addr  input  32  byte address from MEM stage.
REQ-007 WriteData  input  32  store data from MEM stage.
REQ-008 ReadData  output  32  registered load result to pipeline.
REQ-009 Stall  output  1  freeze IF/ID/EX/MEM pipeline registers.
REQ-010 MemA  output  32  address to data memory.
REQ-011 MemWD  output  32  write data to data memory.
REQ-012 MemWE  output  1  write enable to data memory.
REQ-013 MemReady  input  1  memory-side completion strobe, valid only while request presented.
REQ-014 MemRD  input  32  memory read data, valid in MemReady cycle.
REQ-015 Timeout  output  1  sticky abort flag.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE.
REQ-017 IDLE: if MemRead|MemWrite, Stall SHALL be 1 combinationally that cycle; Addr (low 2 bits forced 00), WriteData, op latched at edge; next WAIT.
REQ-018 MemRead and MemWrite both high SHALL be treated as write.
REQ-019 IDLE with no request: Stall=0, MemWE=0, MemReady ignored.
REQ-020 WAIT: MemA/MemWD SHALL drive latched values, stable every cycle; MemWE=1 only if latched op is write; Stall=1.
REQ-021 WAIT with MemReady=1: read SHALL load MemRD into ReadData at that edge; write leaves ReadData unchanged; next DONE.
REQ-022 DONE: Stall=0, MemWE=0 for exactly one cycle; request inputs ignored (still show the completed op); next IDLE.
REQ-023 Wait counter SHALL clear on IDLE->WAIT, increment each WAIT cycle without MemReady, width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-024 Counter reaching TIMEOUT_CYCLES in WAIT with MemReady=0: Timeout SHALL set (sticky), read loads ReadData=0, next DONE.
REQ-025 MemReady and timeout in same cycle: MemReady SHALL win, Timeout not set.
REQ-026 MemWE SHALL never be 1 outside WAIT.
REQ-027 Total Stall per access = 1 + cycles in WAIT up to and including MemReady cycle.
REQ-028 Back-to-back accesses: minimum request-to-request spacing 3 cycles (IDLE, WAIT, DONE).

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE, counter 0, ReadData 0, Timeout 0, latched regs 0, irrespective of state.
REQ-030 Reset mid-WAIT SHALL drop MemWE to 0 from the following cycle; the aborted access is not retried.
REQ-031 While Reset=1, Stall SHALL be 0.

Structure
REQ-032 State encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10) and TIMEOUT_CYCLES default SHALL live in the shared pipeline package.
REQ-033 Wait counter SHALL be a sub-module wait_timer (clear, enable, limit, expired).

Verification
REQ-034 Load Addr=0x0000_0010, MemReady pulsed 3rd WAIT cycle with MemRD=0xDEAD_BEEF -> Stall=1 for 4 cycles, ReadData=0xDEAD_BEEF in DONE, MemA=0x10 throughout.
REQ-035 Store Addr=0x13, WriteData=0x1234_5678, MemReady 1st WAIT cycle -> MemA=0x10, MemWE=1 exactly 1 cycle, ReadData unchanged.
REQ-036 Load, MemReady held 0 for 15 WAIT cycles -> Timeout=1 sticky, ReadData=0, Stall released after 16 cycles.
REQ-037 MemRead=MemWrite=1 -> write issued, MemWE=1 in WAIT.
REQ-038 Reset asserted 2nd WAIT cycle of store -> next cycle IDLE, MemWE=0, Stall=0, ReadData=0.
REQ-039 Request inputs held through DONE then new load -> no duplicate access; second WAIT starts 3 cycles after first request.
